// File: rtl/ad4003_cfg_sequencer_if.sv
// Control/readback bundle between the carrier register block, the AD4003 deserializer
// and the configuration sequencer. AD4003_CFG_WATCHDOG_EN adds the wdog_trip status line.
interface ad4003_cfg_sequencer_if;
    logic       start;
    logic [7:0] cfg_word;
    logic [5:0] adc_spi_clk_count;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       force_write;
    logic       force_read;
    logic       acq_en;
    logic       busy;
    logic       cfg_ok;
    logic       cfg_fail;
    logic [1:0] retry_cnt;
`ifdef AD4003_CFG_WATCHDOG_EN
    logic       wdog_trip;

    modport master (
        output start, cfg_word, adc_spi_clk_count, rd_data, rd_valid,
        input  force_write, force_read, acq_en, busy, cfg_ok, cfg_fail, retry_cnt, wdog_trip
    );

    modport slave (
        input  start, cfg_word, adc_spi_clk_count, rd_data, rd_valid,
        output force_write, force_read, acq_en, busy, cfg_ok, cfg_fail, retry_cnt, wdog_trip
    );
`else
    modport master (
        output start, cfg_word, adc_spi_clk_count, rd_data, rd_valid,
        input  force_write, force_read, acq_en, busy, cfg_ok, cfg_fail, retry_cnt
    );

    modport slave (
        input  start, cfg_word, adc_spi_clk_count, rd_data, rd_valid,
        output force_write, force_read, acq_en, busy, cfg_ok, cfg_fail, retry_cnt
    );
`endif
endinterface

// File: rtl/ad4003_cfg_sequencer.sv
// Power-up configuration sequencer for the AD4003: write frame, readback frame, compare, retry.
// Optional macro AD4003_CFG_WATCHDOG_EN adds a RUN-state readback watchdog (wdog_trip).
module ad4003_cfg_sequencer #(
    parameter int FRAME_LEN  = 34,
    parameter int MAX_RETRY  = 3,
    parameter int GAP_CYCLES = 8
) (
    input  logic                      adc_spi_clk,
    input  logic                      rst,
    ad4003_cfg_sequencer_if.slave     bus
);

    localparam int         GAP_W     = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [5:0] LAST_POS  = 6'(FRAME_LEN - 1);
    localparam logic [1:0] RETRY_MAX = 2'(MAX_RETRY);
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_CYCLES - 1);

    typedef enum logic [3:0] {
        IDLE, ALIGN, WR, GAP1, ALIGN_R, RD, CHECK, GAP2, RUN, FAIL
    } state_t;

    state_t           state_reg;
    logic [7:0]       cfg_q_reg;
    logic [7:0]       rd_q_reg;
    logic             rd_seen_reg;
    logic [GAP_W-1:0] gap_reg;
    logic             force_write_reg;
    logic             force_read_reg;
    logic             acq_en_reg;
    logic             busy_reg;
    logic             cfg_ok_reg;
    logic             cfg_fail_reg;
    logic [1:0]       retry_cnt_reg;

    logic frame_end;
    logic start_accept;

    assign frame_end    = (bus.adc_spi_clk_count == LAST_POS);
    assign start_accept = bus.start &&
                          ((state_reg == IDLE) || (state_reg == RUN) || (state_reg == FAIL));

`ifdef AD4003_CFG_WATCHDOG_EN
    logic [15:0] wdog_cnt_reg;
    logic        wdog_trip_reg;
    assign bus.wdog_trip = wdog_trip_reg;
`endif

    always_ff @(posedge adc_spi_clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            cfg_q_reg       <= 8'd0;
            rd_q_reg        <= 8'd0;
            rd_seen_reg     <= 1'b0;
            gap_reg         <= '0;
            force_write_reg <= 1'b0;
            force_read_reg  <= 1'b0;
            acq_en_reg      <= 1'b0;
            busy_reg        <= 1'b0;
            cfg_ok_reg      <= 1'b0;
            cfg_fail_reg    <= 1'b0;
            retry_cnt_reg   <= 2'd0;
`ifdef AD4003_CFG_WATCHDOG_EN
            wdog_cnt_reg    <= 16'd0;
            wdog_trip_reg   <= 1'b0;
`endif
        end else if (start_accept) begin
            // A fresh sequence always restarts from frame alignment with a clean retry count.
            state_reg     <= ALIGN;
            cfg_q_reg     <= bus.cfg_word;
            retry_cnt_reg <= 2'd0;
            busy_reg      <= 1'b1;
            acq_en_reg    <= 1'b0;
            cfg_ok_reg    <= 1'b0;
            cfg_fail_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ALIGN: begin
                    if (frame_end) begin
                        state_reg       <= WR;
                        force_write_reg <= 1'b1;
                    end
                end
                WR: begin
                    if (frame_end) begin
                        state_reg       <= GAP1;
                        force_write_reg <= 1'b0;
                        gap_reg         <= GAP_LOAD;
                    end
                end
                GAP1: begin
                    if (gap_reg == '0) begin
                        state_reg <= ALIGN_R;
                    end else begin
                        gap_reg <= gap_reg - 1'b1;
                    end
                end
                ALIGN_R: begin
                    if (frame_end) begin
                        state_reg      <= RD;
                        force_read_reg <= 1'b1;
                        rd_seen_reg    <= 1'b0;
                    end
                end
                RD: begin
                    // Later strobes overwrite earlier ones, so the last byte of the frame is judged.
                    if (bus.rd_valid) begin
                        rd_q_reg    <= bus.rd_data;
                        rd_seen_reg <= 1'b1;
                    end
                    if (frame_end) begin
                        state_reg      <= CHECK;
                        force_read_reg <= 1'b0;
                    end
                end
                CHECK: begin
                    if (rd_seen_reg && (rd_q_reg == cfg_q_reg)) begin
                        state_reg  <= RUN;
                        acq_en_reg <= 1'b1;
                        cfg_ok_reg <= 1'b1;
                        busy_reg   <= 1'b0;
`ifdef AD4003_CFG_WATCHDOG_EN
                        wdog_cnt_reg  <= 16'd0;
                        wdog_trip_reg <= 1'b0;
`endif
                    end else if (retry_cnt_reg < RETRY_MAX) begin
                        state_reg     <= GAP2;
                        retry_cnt_reg <= retry_cnt_reg + 2'd1;
                        gap_reg       <= GAP_LOAD;
                    end else begin
                        state_reg    <= FAIL;
                        cfg_fail_reg <= 1'b1;
                        busy_reg     <= 1'b0;
                    end
                end
                GAP2: begin
                    if (gap_reg == '0) begin
                        state_reg <= ALIGN;
                    end else begin
                        gap_reg <= gap_reg - 1'b1;
                    end
                end
                RUN: begin
`ifdef AD4003_CFG_WATCHDOG_EN
                    // Too many frames without a readback strobe: assume the ADC lost its config.
                    if (wdog_cnt_reg == 16'hFFFF) begin
                        state_reg     <= ALIGN;
                        wdog_trip_reg <= 1'b1;
                        wdog_cnt_reg  <= 16'd0;
                        acq_en_reg    <= 1'b0;
                        cfg_ok_reg    <= 1'b0;
                        busy_reg      <= 1'b1;
                        retry_cnt_reg <= 2'd0;
                    end else if (bus.rd_valid) begin
                        wdog_cnt_reg <= 16'd0;
                    end else if (frame_end) begin
                        wdog_cnt_reg <= wdog_cnt_reg + 16'd1;
                    end
`endif
                end
                IDLE, FAIL: begin
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.force_write = force_write_reg;
    assign bus.force_read  = force_read_reg;
    assign bus.acq_en      = acq_en_reg;
    assign bus.busy        = busy_reg;
    assign bus.cfg_ok      = cfg_ok_reg;
    assign bus.cfg_fail    = cfg_fail_reg;
    assign bus.retry_cnt   = retry_cnt_reg;

endmodule

// File: tb/tb_ad4003_cfg_sequencer.sv
// Directed bench for ad4003_cfg_sequencer: the bench plays the deserializer (frame counter
// and readback strobe) and checks frame timing, retry accounting and final status.
module tb_ad4003_cfg_sequencer;

    localparam int FRAME_LEN = 34;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    ad4003_cfg_sequencer_if bus ();

    ad4003_cfg_sequencer #(
        .FRAME_LEN (34),
        .MAX_RETRY (3),
        .GAP_CYCLES(8)
    ) dut (
        .adc_spi_clk(clk),
        .rst        (rst),
        .bus        (bus)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One clock: inputs driven here are seen at the next rising edge; outputs read
    // afterwards reflect the edge just taken. The frame counter free-runs 0..33.
    task automatic tick();
        @(posedge clk);
        #1;
        bus.adc_spi_clk_count = (bus.adc_spi_clk_count == 6'(FRAME_LEN - 1)) ?
                                6'd0 : bus.adc_spi_clk_count + 6'd1;
    endtask

    function automatic logic [7:0] outs();
        return {bus.force_write, bus.force_read, bus.acq_en, bus.busy,
                bus.cfg_ok, bus.cfg_fail, bus.retry_cnt};
    endfunction

    task automatic do_start(input logic [7:0] word);
        bus.cfg_word = word;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        $display("[TB] start cfg_word=0x%02h", word);
    endtask

    // One write/read attempt as seen from the deserializer side; returns one cycle after CHECK.
    task automatic attempt(input string tag, input logic [7:0] reply,
                           input bit give_valid, input bit poke_start);
        int n;
        bit overlap;
        n = 0;
        while (!bus.force_write && n < 300) begin
            tick();
            n++;
        end
        chk({tag, "_wr_rise"}, 32'(n < 300), 32'd1);
        chk({tag, "_wr_align"}, 32'(bus.adc_spi_clk_count), 32'd0);
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        overlap = 1'b0;
        while (bus.force_write && n < 100) begin
            if (bus.force_read) overlap = 1'b1;
            tick();
            n++;
        end
        chk({tag, "_wr_len"}, 32'(n), 32'(FRAME_LEN));
        chk({tag, "_overlap"}, 32'(overlap), 32'd0);
        n = 0;
        while (!bus.force_read && n < 100) begin
            tick();
            n++;
        end
        chk({tag, "_gap_to_rd"}, 32'(n), 32'(FRAME_LEN));
        chk({tag, "_rd_align"}, 32'(bus.adc_spi_clk_count), 32'd0);
        n = 0;
        while (bus.force_read && n < 100) begin
            bus.rd_valid = give_valid && (bus.adc_spi_clk_count == 6'd20);
            bus.rd_data  = reply;
            if (poke_start && bus.adc_spi_clk_count == 6'd10) begin
                bus.cfg_word = 8'h55;
                bus.start    = 1'b1;
            end else begin
                bus.start    = 1'b0;
            end
            tick();
            n++;
        end
        bus.rd_valid = 1'b0;
        bus.start    = 1'b0;
        chk({tag, "_rd_len"}, 32'(n), 32'(FRAME_LEN));
        tick();
        $display("[TB] %s reply=0x%02h valid=%0d -> acq_en=%0d cfg_fail=%0d retry_cnt=%0d",
                 tag, reply, give_valid, bus.acq_en, bus.cfg_fail, bus.retry_cnt);
    endtask

    initial begin
        int n;
        bit fw_seen;
        bus.start             = 1'b0;
        bus.cfg_word          = 8'h00;
        bus.adc_spi_clk_count = 6'd0;
        bus.rd_data           = 8'h00;
        bus.rd_valid          = 1'b0;

        // Reset held 20 cycles, then idle with no start.
        rst = 1'b1;
        for (int i = 0; i < 20; i++) tick();
        chk("reset_outs", 32'(outs()), 32'd0);
        rst = 1'b0;
        fw_seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            tick();
            if (bus.force_write || bus.force_read) fw_seen = 1'b1;
        end
        chk("idle_no_force", 32'(fw_seen), 32'd0);
        chk("idle_outs", 32'(outs()), 32'd0);
        $display("[TB] reset/idle done");

        // Clean pass, ALIGN entered at count 0.
        while (bus.adc_spi_clk_count != 6'd33) tick();
        do_start(8'h14);
        chk("t2_busy", 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.force_write && n < 300) begin
            tick();
            n++;
        end
        chk("t2_first_wr_latency", 32'(n), 32'(FRAME_LEN));
        attempt("t2", 8'h14, 1'b1, 1'b0);
        chk("t2_run_outs", 32'(outs()), 32'b0010_1000);
        for (int i = 0; i < 10; i++) tick();
        chk("t2_run_hold", 32'(bus.acq_en), 32'd1);

        // Two mismatches then a match.
        do_start(8'h14);
        chk("t3_acq_drop", 32'({bus.acq_en, bus.cfg_ok, bus.busy}), 32'b001);
        attempt("t3a", 8'h00, 1'b1, 1'b0);
        chk("t3a_retry", 32'({bus.retry_cnt, bus.busy, bus.acq_en}), 32'b0110);
        attempt("t3b", 8'h00, 1'b1, 1'b0);
        chk("t3b_retry", 32'(bus.retry_cnt), 32'd2);
        attempt("t3c", 8'h14, 1'b1, 1'b0);
        chk("t3_run_outs", 32'(outs()), 32'b0010_1010);

        // Readback never matches: four attempts then FAIL.
        do_start(8'h14);
        chk("t4_retry_clr", 32'(bus.retry_cnt), 32'd0);
        attempt("t4a", 8'hFF, 1'b1, 1'b0);
        chk("t4a_retry", 32'(bus.retry_cnt), 32'd1);
        attempt("t4b", 8'hFF, 1'b1, 1'b0);
        chk("t4b_retry", 32'(bus.retry_cnt), 32'd2);
        attempt("t4c", 8'hFF, 1'b1, 1'b0);
        chk("t4c_retry", 32'(bus.retry_cnt), 32'd3);
        attempt("t4d", 8'hFF, 1'b1, 1'b0);
        chk("t4_fail_outs", 32'(outs()), 32'b0000_0111);
        fw_seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            tick();
            if (bus.force_write || bus.force_read) fw_seen = 1'b1;
        end
        chk("t4_fail_quiet", 32'(fw_seen), 32'd0);
        chk("t4_fail_hold", 32'(outs()), 32'b0000_0111);
        do_start(8'h3C);
        chk("t4_restart", 32'({bus.cfg_fail, bus.retry_cnt, bus.busy}), 32'b0001);
        attempt("t4e", 8'h3C, 1'b1, 1'b0);
        chk("t4_recover_outs", 32'(outs()), 32'b0010_1000);

        // Reset in the middle of a write frame.
        do_start(8'h14);
        n = 0;
        while (!bus.force_write && n < 300) begin
            tick();
            n++;
        end
        chk("t5_wr_rise", 32'(n < 300), 32'd1);
        while (bus.adc_spi_clk_count != 6'd10) tick();
        rst = 1'b1;
        tick();
        chk("t5_rst_outs", 32'(outs()), 32'd0);
        rst = 1'b0;
        tick();
        chk("t5_idle", 32'(outs()), 32'd0);
        do_start(8'h14);
        attempt("t5", 8'h14, 1'b1, 1'b0);
        chk("t5_run_outs", 32'(outs()), 32'b0010_1000);

        // start during RD is ignored; a read frame without rd_valid is a mismatch.
        do_start(8'h14);
        attempt("t6a", 8'h14, 1'b1, 1'b1);
        chk("t6a_start_ignored", 32'(outs()), 32'b0010_1000);
        do_start(8'h14);
        attempt("t6b", 8'h14, 1'b0, 1'b0);
        chk("t6b_no_valid_retry", 32'({bus.retry_cnt, bus.acq_en, bus.busy}), 32'b0101);
        attempt("t6c", 8'h14, 1'b1, 1'b0);
        chk("t6c_run_outs", 32'(outs()), 32'b0010_1001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
